// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: millisecond tick and debounced buttons in,
// display-facing time, mode and status out.
interface stopwatch_ctrl_if #(
  parameter int COUNT_W = 39
);
  logic               ms_tick;
  logic               btn_start;
  logic               btn_lap;
  logic               btn_clear;
  logic [COUNT_W-1:0] count;
  logic [1:0]         mode;
  logic [7:0]         decs;
  logic               running;
  logic               wrap;

  modport master (
    output ms_tick, btn_start, btn_lap, btn_clear,
    input  count, mode, decs, running, wrap
  );

  modport slave (
    input  ms_tick, btn_start, btn_lap, btn_clear,
    output count, mode, decs, running, wrap
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop, lap freeze and clear over a modulo-MAX_MS
// millisecond counter, with registered display outputs.
module stopwatch_ctrl #(
  parameter int MAX_MS  = 3600000,
  parameter int COUNT_W = 39
) (
  input  logic            clock,
  input  logic            reset,
  stopwatch_ctrl_if.slave sw
);
  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    RUN_S   = 2'd1,
    PAUSE_S = 2'd2,
    LAP_S   = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] LAST_C = COUNT_W'(MAX_MS - 1);

  state_t             state_r, state_next_s;
  logic [COUNT_W-1:0] cnt_r, cnt_next_s;
  logic [COUNT_W-1:0] lap_r, lap_next_s;
  logic [COUNT_W-1:0] count_r, count_next_s;
  logic [1:0]         mode_r, mode_next_s;
  logic               running_r, running_next_s;
  logic               wrap_r, wrap_next_s;
  logic               start_prev_r, lap_prev_r, clear_prev_r;
  logic               start_press_s, lap_press_s, clear_press_s;

  assign start_press_s = sw.btn_start & ~start_prev_r;
  assign lap_press_s   = sw.btn_lap   & ~lap_prev_r;
  assign clear_press_s = sw.btn_clear & ~clear_prev_r;

  // Next-state, counter and registered-output selection
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    lap_next_s   = lap_r;
    wrap_next_s  = 1'b0;

    // Tick is qualified by the state before any transition this cycle
    if (sw.ms_tick && (state_r == RUN_S || state_r == LAP_S)) begin
      if (cnt_r == LAST_C) begin
        cnt_next_s  = '0;
        wrap_next_s = 1'b1;
      end else begin
        cnt_next_s  = cnt_r + COUNT_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end

    case (state_r)
      IDLE_S: begin
        if (start_press_s) state_next_s = RUN_S;
        else               state_next_s = IDLE_S;
      end
      RUN_S: begin
        if (start_press_s) begin
          state_next_s = PAUSE_S;
        end else if (lap_press_s) begin
          state_next_s = LAP_S;
          lap_next_s   = cnt_r;
        end else begin
          state_next_s = RUN_S;
        end
      end
      LAP_S: begin
        if (start_press_s)    state_next_s = PAUSE_S;
        else if (lap_press_s) state_next_s = RUN_S;
        else                  state_next_s = LAP_S;
      end
      PAUSE_S: begin
        if (clear_press_s) begin
          state_next_s = IDLE_S;
          cnt_next_s   = '0;
        end else if (start_press_s) begin
          state_next_s = RUN_S;
        end else begin
          state_next_s = PAUSE_S;
        end
      end
      default: begin
        state_next_s = IDLE_S;
      end
    endcase

    count_next_s   = (state_next_s == LAP_S) ? lap_next_s : cnt_next_s;
    mode_next_s    = (state_next_s == IDLE_S) ? 2'd0 : 2'd2;
    running_next_s = (state_next_s == RUN_S) || (state_next_s == LAP_S);
  end

  // State, counters, button history and display outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE_S;
      cnt_r        <= '0;
      lap_r        <= '0;
      count_r      <= '0;
      mode_r       <= 2'd0;
      running_r    <= 1'b0;
      wrap_r       <= 1'b0;
      start_prev_r <= 1'b0;
      lap_prev_r   <= 1'b0;
      clear_prev_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      lap_r        <= lap_next_s;
      count_r      <= count_next_s;
      mode_r       <= mode_next_s;
      running_r    <= running_next_s;
      wrap_r       <= wrap_next_s;
      start_prev_r <= sw.btn_start;
      lap_prev_r   <= sw.btn_lap;
      clear_prev_r <= sw.btn_clear;
    end
  end

  assign sw.count   = count_r;
  assign sw.mode    = mode_r;
  assign sw.running = running_r;
  assign sw.wrap    = wrap_r;
  assign sw.decs    = 8'b00101000;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a default-modulus instance and a
// MAX_MS=8 instance share one stimulus stream.
module tb_stopwatch_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ms_tick = 1'b0;
  logic btn_start = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  stopwatch_ctrl_if #(.COUNT_W(39)) sw ();
  stopwatch_ctrl_if #(.COUNT_W(39)) sw8 ();

  assign sw.ms_tick    = ms_tick;
  assign sw.btn_start  = btn_start;
  assign sw.btn_lap    = btn_lap;
  assign sw.btn_clear  = btn_clear;
  assign sw8.ms_tick   = ms_tick;
  assign sw8.btn_start = btn_start;
  assign sw8.btn_lap   = btn_lap;
  assign sw8.btn_clear = btn_clear;

  stopwatch_ctrl #(.MAX_MS(3600000), .COUNT_W(39)) dut (
    .clock (clock),
    .reset (reset),
    .sw    (sw)
  );

  stopwatch_ctrl #(.MAX_MS(8), .COUNT_W(39)) dut8 (
    .clock (clock),
    .reset (reset),
    .sw    (sw8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic tk, input logic st, input logic lp, input logic cl);
    ms_tick   = tk;
    btn_start = st;
    btn_lap   = lp;
    btn_clear = cl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1;
    check("rst_count",   64'(sw.count),   64'd0);
    check("rst_mode",    64'(sw.mode),    64'd0);
    check("rst_running", 64'(sw.running), 64'd0);
    check("rst_wrap",    64'(sw.wrap),    64'd0);
    check("rst_decs",    64'(sw.decs),    64'h28);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_count", 64'(sw.count), 64'd0);
    check("idle_decs",  64'(sw.decs),  64'h28);

    // start, 5 ticks, pause, 3 ignored ticks
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_running", 64'(sw.running), 64'd1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("run5_count",   64'(sw.count),   64'd5);
    check("run5_running", 64'(sw.running), 64'd1);
    check("run5_mode",    64'(sw.mode),    64'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_running", 64'(sw.running), 64'd0);
    check("pause_mode",    64'(sw.mode),    64'd2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_hold", 64'(sw.count), 64'd5);

    // tick coinciding with a stop press still counts
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("tick_stop_count",   64'(sw.count),   64'd6);
    check("tick_stop_running", 64'(sw.running), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // modulus-8 instance rolls 7 -> 0 with a single wrap pulse
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("m8_at7",      64'(sw8.count), 64'd7);
    check("m8_nowrap",   64'(sw8.wrap),  64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("m8_rollover", 64'(sw8.count), 64'd0);
    check("m8_wrap",     64'(sw8.wrap),  64'd1);
    check("big_nowrap",  64'(sw.wrap),   64'd0);
    check("big_at8",     64'(sw.count),  64'd8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("m8_wrap_end", 64'(sw8.wrap),  64'd0);
    check("m8_hold0",    64'(sw8.count), 64'd0);

    // lap freezes the display; internal count keeps running
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("run10", 64'(sw.count), 64'd10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_count",   64'(sw.count),   64'd10);
    check("lap_running", 64'(sw.running), 64'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("lap_frozen", 64'(sw.count), 64'd10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_release", 64'(sw.count), 64'd14);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // clear ignored while running
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("run_clear_count",   64'(sw.count),   64'd14);
    check("run_clear_running", 64'(sw.running), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("run20", 64'(sw.count), 64'd20);

    // in RUN, clear is not valid so start wins
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("run_clr_start_running", 64'(sw.running), 64'd0);
    check("run_clr_start_count",   64'(sw.count),   64'd20);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("pause_lap_ignored", 64'(sw.running), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // in PAUSE, clear beats start
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("clear_count",   64'(sw.count),   64'd0);
    check("clear_mode",    64'(sw.mode),    64'd0);
    check("clear_running", 64'(sw.running), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("idle_ignore_count", 64'(sw.count), 64'd0);
    check("idle_ignore_mode",  64'(sw.mode),  64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // start held 100 cycles with ticks: one press, then 99 counted ticks
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_running", 64'(sw.running), 64'd1);
    check("hold_count",   64'(sw.count),   64'd99);

    // async reset in LAP, before the next edge
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap99", 64'(sw.count), 64'd99);
    #2;
    btn_start = 1'b1;
    btn_lap   = 1'b0;
    reset     = 1'b1;
    #1;
    check("async_rst_count",   64'(sw.count),   64'd0);
    check("async_rst_running", 64'(sw.running), 64'd0);
    check("async_rst_mode",    64'(sw.mode),    64'd0);
    check("async_rst_wrap",    64'(sw.wrap),    64'd0);
    check("async_rst_decs",    64'(sw.decs),    64'h28);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("held_at_reset_run", 64'(sw.running), 64'd1);
    check("held_at_reset_cnt", 64'(sw.count),   64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("after_reset_tick",  64'(sw.count),   64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
